// File: rtl/reg_file_psr_pkg.sv
// Shared constants for the register file / PSR slice: default widths,
// PSR bit positions and the common flag write masks used by the decoder.
package reg_file_psr_pkg;

    localparam int unsigned WIDTH_DATA_DEFAULT = 16;
    localparam int unsigned WIDTH_ADDR_DEFAULT = 4;

    localparam int unsigned NUM_FLAGS = 5;

    // PSR bit positions, {C,L,F,N,Z} = [4:0]
    localparam int unsigned PSR_C = 4;
    localparam int unsigned PSR_L = 3;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_N = 1;
    localparam int unsigned PSR_Z = 0;

    // Flag write masks per instruction class
    localparam logic [NUM_FLAGS-1:0] FLAGS_NONE  = 5'b00000;
    localparam logic [NUM_FLAGS-1:0] FLAGS_ARITH = 5'b11111;
    localparam logic [NUM_FLAGS-1:0] FLAGS_CMP   = 5'b01011;
    localparam logic [NUM_FLAGS-1:0] FLAGS_LOGIC = 5'b00011;

endpackage

// File: rtl/reg_file_psr_psr_reg.sv
// Processor status register: 5 flags, each updated only when its mask bit
// is set, cleared asynchronously by reset.
module reg_file_psr_psr_reg
    import reg_file_psr_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_FLAGS-1:0] flag_we_i,
    input  logic [NUM_FLAGS-1:0] flags_i,
    output logic [NUM_FLAGS-1:0] psr_o
);

    logic [NUM_FLAGS-1:0] psr_d;
    logic [NUM_FLAGS-1:0] psr_q;

    // Per-bit merge of new flags under the write mask
    always_comb begin
        psr_d = psr_q;
        for (int i = 0; i < int'(NUM_FLAGS); i++) begin
            if (flag_we_i[i]) begin
                psr_d[i] = flags_i[i];
            end
        end
    end

    // Flag storage with asynchronous clear
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr_o = psr_q;

endmodule

// File: rtl/reg_file_psr.sv
// General register file with two combinational read ports, one write port,
// optional write-to-read bypass, and the ALU status register.
module reg_file_psr
    import reg_file_psr_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEFAULT,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned WIDTH_ADDR = $clog2(NUM_REGS),
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH_ADDR-1:0] wr_addr_i,
    input  logic [WIDTH_DATA-1:0] wr_data_i,
    input  logic [WIDTH_ADDR-1:0] rd_addr_a_i,
    input  logic [WIDTH_ADDR-1:0] rd_addr_b_i,
    output logic [WIDTH_DATA-1:0] rd_data_a_o,
    output logic [WIDTH_DATA-1:0] rd_data_b_o,
    input  logic [NUM_FLAGS-1:0]  flag_we_i,
    input  logic                  carry_i,
    input  logic                  low_i,
    input  logic                  over_i,
    input  logic                  neg_i,
    input  logic                  zero_i,
    output logic [NUM_FLAGS-1:0]  psr_o,
    output logic                  psr_carry_o
);

    logic [WIDTH_DATA-1:0] regs_q [NUM_REGS];
    logic [WIDTH_DATA-1:0] regs_d [NUM_REGS];
    logic [NUM_FLAGS-1:0]  flags;

    // Next-state of the array: only the addressed register changes
    always_comb begin
        regs_d = regs_q;
        if (wr_en_i) begin
            regs_d[wr_addr_i] = wr_data_i;
        end
    end

    // Register array, asynchronously cleared; r0 is an ordinary register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes; bypass relies on wr_data_i being registered upstream so no loop forms
    always_comb begin
        rd_data_a_o = regs_q[rd_addr_a_i];
        rd_data_b_o = regs_q[rd_addr_b_i];
        if (BYPASS_EN && wr_en_i) begin
            if (rd_addr_a_i == wr_addr_i) begin
                rd_data_a_o = wr_data_i;
            end
            if (rd_addr_b_i == wr_addr_i) begin
                rd_data_b_o = wr_data_i;
            end
        end
    end

    assign flags = {carry_i, low_i, over_i, neg_i, zero_i};

    reg_file_psr_psr_reg u_psr_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flag_we_i (flag_we_i),
        .flags_i   (flags),
        .psr_o     (psr_o)
    );

    assign psr_carry_o = psr_o[PSR_C];

endmodule

// File: tb/tb_reg_file_psr.sv
// Bench for reg_file_psr: one bypassing and one non-bypassing instance share
// all inputs; expected values are queued as stimulus is driven and popped
// when the outputs are sampled.
module tb_reg_file_psr;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [4:0]  flag_we;
    logic        carry_in, low_in, over_in, neg_in, zero_in;

    logic [15:0] rda_byp, rdb_byp, rda_nb, rdb_nb;
    logic [4:0]  psr_byp, psr_nb;
    logic        pc_byp, pc_nb;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   vec_cnt;
    int   err_cnt;

    reg_file_psr #(.BYPASS_EN(1'b1)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
        .rd_data_a_o(rda_byp), .rd_data_b_o(rdb_byp), .flag_we_i(flag_we),
        .carry_i(carry_in), .low_i(low_in), .over_i(over_in), .neg_i(neg_in),
        .zero_i(zero_in), .psr_o(psr_byp), .psr_carry_o(pc_byp)
    );

    reg_file_psr #(.BYPASS_EN(1'b0)) dut_nb (
        .clk_i(clk), .reset_n_i(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
        .rd_data_a_o(rda_nb), .rd_data_b_o(rdb_nb), .flag_we_i(flag_we),
        .carry_i(carry_in), .low_i(low_in), .over_i(over_in), .neg_i(neg_in),
        .zero_i(zero_in), .psr_o(psr_nb), .psr_carry_o(pc_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: one register write, inputs driven on the falling edge
    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic set_flags(input logic [4:0] we, input logic [4:0] f);
        flag_we = we;
        {carry_in, low_in, over_in, neg_in, zero_in} = f;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            rd_addr_b = 4'(15 - a);
            sb_q.push_back('{"reset rd_a", 16'h0000});
            sb_q.push_back('{"reset rd_b", 16'h0000});
            #1;
            e = sb_q.pop_front();
            vec_cnt++;
            if (rda_byp !== e.val) begin
                err_cnt++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, a, rda_byp, e.val);
            end
            e = sb_q.pop_front();
            vec_cnt++;
            if (rdb_byp !== e.val) begin
                err_cnt++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, 15 - a, rdb_byp, e.val);
            end
        end
        sb_q.push_back('{"reset psr", 16'h0000});
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
    endtask

    task automatic test_write_read();
        do_write(4'd3, 16'hBEEF);
        do_write(4'd15, 16'h1234);
        do_write(4'd0, 16'h0A0A);
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd15;
        sb_q.push_back('{"wr rd_a r3", 16'hBEEF});
        sb_q.push_back('{"wr rd_b r15", 16'h1234});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rdb_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rdb_byp, e.val);
        end
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd3;
        sb_q.push_back('{"wr rd_a r0", 16'h0A0A});
        sb_q.push_back('{"wr rd_b r3", 16'hBEEF});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rdb_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rdb_byp, e.val);
        end
        // Both ports on the same register
        rd_addr_a = 4'd3;
        sb_q.push_back('{"same rd_a", 16'hBEEF});
        sb_q.push_back('{"same rd_b", 16'hBEEF});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rdb_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rdb_byp, e.val);
        end
    endtask

    task automatic test_bypass();
        do_write(4'd5, 16'h0001);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = 4'd5;
        wr_data   = 16'hFFFF;
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd6;
        sb_q.push_back('{"bypass rd_a pre-edge", 16'hFFFF});
        sb_q.push_back('{"bypass rd_b other reg", 16'h0000});
        sb_q.push_back('{"no-bypass rd_a pre-edge", 16'h0001});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rdb_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rdb_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_nb !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_nb, e.val);
        end
        // Port B bypass alone
        rd_addr_a = 4'd6;
        rd_addr_b = 4'd5;
        sb_q.push_back('{"bypass rd_b pre-edge", 16'hFFFF});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rdb_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rdb_byp, e.val);
        end
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_addr_a = 4'd5;
        sb_q.push_back('{"no-bypass rd_a post-edge", 16'hFFFF});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_nb !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_nb, e.val);
        end
    endtask

    task automatic test_psr_mask();
        @(negedge clk);
        set_flags(5'b11111, 5'b10101);
        @(posedge clk);
        #1;
        sb_q.push_back('{"psr all", 16'h0015});
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
        @(negedge clk);
        set_flags(5'b00001, 5'b11110);
        @(posedge clk);
        #1;
        sb_q.push_back('{"psr z only", 16'h0014});
        sb_q.push_back('{"psr_carry", 16'h0001});
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if ({15'd0, pc_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, pc_byp, e.val);
        end
        @(negedge clk);
        set_flags(5'b00000, 5'b01011);
        @(posedge clk);
        #1;
        sb_q.push_back('{"psr hold", 16'h0014});
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
    endtask

    task automatic test_back_to_back();
        // Register write and CMP-style flag update on the same edge
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'd7;
        wr_data = 16'hA5A5;
        set_flags(5'b01011, 5'b00010);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        set_flags(5'b00000, 5'b00000);
        rd_addr_a = 4'd7;
        sb_q.push_back('{"b2b psr", 16'h0016});
        sb_q.push_back('{"b2b r7", 16'hA5A5});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
    endtask

    task automatic test_alu();
        logic [15:0] a_v [2];
        logic [15:0] b_v;
        logic [16:0] sum;
        logic        ovf;
        logic [4:0]  f;
        logic [15:0] exp_psr [2];
        a_v[0]     = 16'hFFFF;
        a_v[1]     = 16'h7FFF;
        b_v        = 16'h0001;
        exp_psr[0] = 16'h0011;  // C,Z
        exp_psr[1] = 16'h0006;  // F,N
        do_write(4'd2, b_v);
        for (int k = 0; k < 2; k++) begin
            do_write(4'd1, a_v[k]);
            rd_addr_a = 4'd1;
            rd_addr_b = 4'd2;
            sb_q.push_back('{"alu opA", a_v[k]});
            #1;
            e = sb_q.pop_front();
            vec_cnt++;
            if (rda_byp !== e.val) begin
                err_cnt++;
                $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
            end
            sum = {1'b0, a_v[k]} + {1'b0, b_v};
            ovf = (a_v[k][15] == b_v[15]) && (sum[15] != a_v[k][15]);
            f   = {sum[16], (a_v[k] < b_v), ovf, sum[15], (sum[15:0] == 16'h0)};
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 4'd4;
            wr_data = sum[15:0];
            set_flags(5'b11111, f);
            sb_q.push_back('{"alu r4", sum[15:0]});
            sb_q.push_back('{"alu psr", exp_psr[k]});
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            set_flags(5'b00000, 5'b00000);
            rd_addr_a = 4'd4;
            #1;
            e = sb_q.pop_front();
            vec_cnt++;
            if (rda_byp !== e.val) begin
                err_cnt++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, k, rda_byp, e.val);
            end
            e = sb_q.pop_front();
            vec_cnt++;
            if ({11'd0, psr_byp} !== e.val) begin
                err_cnt++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, k, psr_byp, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = 4'd9;
        wr_data   = 16'h1357;
        set_flags(5'b11111, 5'b11111);
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd4;
        #2;
        reset_n = 1'b0;
        #1;
        sb_q.push_back('{"async rd_a r3", 16'h0000});
        sb_q.push_back('{"async rd_b r4", 16'h0000});
        sb_q.push_back('{"async psr", 16'h0000});
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (rdb_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rdb_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        set_flags(5'b00000, 5'b00000);
        rd_addr_a = 4'd9;
        sb_q.push_back('{"async no write r9", 16'h0000});
        sb_q.push_back('{"async psr held clear", 16'h0000});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if ({11'd0, psr_byp} !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, psr_byp, e.val);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_write(4'd9, 16'h2468);
        sb_q.push_back('{"first write after reset", 16'h2468});
        #1;
        e = sb_q.pop_front();
        vec_cnt++;
        if (rda_byp !== e.val) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", e.name, rda_byp, e.val);
        end
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        set_flags(5'b00000, 5'b00000);
        test_reset();
        test_write_read();
        test_bypass();
        test_psr_mask();
        test_back_to_back();
        test_alu();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
